inta_sequencer: RTL and testbench

Interrupt-acknowledge sequencer for the 8259 PIC: the CPU-facing end of the acknowledge protocol whose ISR-facing strobes (`ack1`, `ack2`) the in-service register consumes. The block has three jobs:
- Raise `INT` when the priority resolver reports a serviceable request.
- Track the two 8086-mode INTA pulses and emit single-cycle `ack1`/`ack2` strobes to the ISR.
- Drive the cascade bus (master) or decode it (slave), and place the vector byte on the data bus during the second pulse.

---
 rtl/inta_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_inta_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inta_sequencer.sv
// 8259 interrupt-acknowledge sequencer: raises INT, tracks the two INTA pulses, strobes the ISR,
// drives or decodes the cascade bus and puts the vector byte on the data bus.
module inta_sequencer #(
  parameter bit SYNC_INTA = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       int_req,
  input  logic [2:0] highest_priority_idx,
  input  logic [4:0] vector_base,
  input  logic       SNGL,
  input  logic       SP,
  input  logic [7:0] cascade_mask,
  input  logic [2:0] slave_id,
  input  logic       inta_n,
  input  logic [2:0] cas_in,
  output logic       INT,
  output logic       ack1,
  output logic       ack2,
  output logic [2:0] latched_idx,
  output logic       spurious,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  output logic [7:0] data_out,
  output logic       data_oe
);

  typedef enum logic [2:0] {StIdle, StPending, StPulse1, StGap, StPulse2} state_e;

  logic inta_src;

  if (SYNC_INTA) begin : g_sync
    logic sync1_q, sync2_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= inta_n;
        sync2_q <= sync1_q;
      end
    end
    assign inta_src = sync2_q;
  end else begin : g_nosync
    assign inta_src = inta_n;
  end

  state_e     state_q, state_d;
  logic       inta_q, inta_prev_q;
  logic       block_q, block_d;
  logic       holdoff_q, holdoff_d;
  logic       ack_en_q, ack_en_d;
  logic       int_q, int_d;
  logic       ack1_q, ack1_d;
  logic       ack2_q, ack2_d;
  logic [2:0] idx_q, idx_d;
  logic       spur_q, spur_d;
  logic [2:0] cas_out_q, cas_out_d;
  logic       cas_oe_q, cas_oe_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;

  logic       fall, rise;
  logic       is_master, is_slave, responder;
  logic [2:0] idx_sel;

  // After reset, edges stay masked until INTA is seen high, so a pulse cut by reset is dropped.
  assign fall      = ~block_q & inta_prev_q & ~inta_q;
  assign rise      = ~block_q & ~inta_prev_q & inta_q;
  assign is_master = ~SNGL & SP;
  assign is_slave  = ~SNGL & ~SP;
  assign idx_sel   = int_req ? highest_priority_idx : 3'd7;
  assign responder = SNGL | (SP & ~cascade_mask[idx_q]) | (~SP & (cas_in == slave_id));

  always_comb begin
    state_d    = state_q;
    block_d    = block_q & ~inta_q;
    holdoff_d  = 1'b0;
    ack_en_d   = ack_en_q;
    int_d      = int_q;
    ack1_d     = 1'b0;
    ack2_d     = 1'b0;
    idx_d      = idx_q;
    spur_d     = spur_q;
    cas_out_d  = cas_out_q;
    cas_oe_d   = cas_oe_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    unique case (state_q)
      StIdle: begin
        // One idle cycle after ack2 lets the ISR update the resolver before re-sampling.
        if (int_req && !holdoff_q) begin
          state_d = StPending;
          int_d   = 1'b1;
        end
      end
      StPending: begin
        if (fall) begin
          state_d  = StPulse1;
          int_d    = 1'b0;
          idx_d    = idx_sel;
          spur_d   = ~int_req;
          // A slave only learns whether it is addressed at the second pulse; its ack1 waits.
          ack_en_d = int_req & ~is_slave;
          ack1_d   = int_req & ~is_slave;
          if (is_master && cascade_mask[idx_sel]) begin
            cas_oe_d  = 1'b1;
            cas_out_d = idx_sel;
          end
        end
      end
      StPulse1: begin
        if (rise) state_d = StGap;
      end
      StGap: begin
        if (fall) begin
          state_d = StPulse2;
          if (responder) begin
            data_oe_d  = 1'b1;
            data_out_d = {vector_base, idx_q};
          end
          if (is_slave) begin
            ack_en_d = responder & ~spur_q;
            ack1_d   = responder & ~spur_q;
          end
        end
      end
      StPulse2: begin
        if (rise) begin
          state_d   = StIdle;
          data_oe_d = 1'b0;
          cas_oe_d  = 1'b0;
          ack2_d    = ack_en_q;
          ack_en_d  = 1'b0;
          spur_d    = 1'b0;
          holdoff_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      inta_q      <= 1'b1;
      inta_prev_q <= 1'b1;
      block_q     <= 1'b1;
      holdoff_q   <= 1'b0;
      ack_en_q    <= 1'b0;
      int_q       <= 1'b0;
      ack1_q      <= 1'b0;
      ack2_q      <= 1'b0;
      idx_q       <= 3'd0;
      spur_q      <= 1'b0;
      cas_out_q   <= 3'd0;
      cas_oe_q    <= 1'b0;
      data_out_q  <= 8'd0;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      inta_q      <= inta_src;
      inta_prev_q <= inta_q;
      block_q     <= block_d;
      holdoff_q   <= holdoff_d;
      ack_en_q    <= ack_en_d;
      int_q       <= int_d;
      ack1_q      <= ack1_d;
      ack2_q      <= ack2_d;
      idx_q       <= idx_d;
      spur_q      <= spur_d;
      cas_out_q   <= cas_out_d;
      cas_oe_q    <= cas_oe_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign INT         = int_q;
  assign ack1        = ack1_q;
  assign ack2        = ack2_q;
  assign latched_idx = idx_q;
  assign spurious    = spur_q;
  assign cas_out     = cas_out_q;
  assign cas_oe      = cas_oe_q;
  assign data_out    = data_out_q;
  assign data_oe     = data_oe_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer with SYNC_INTA=0 (2-clk edge-to-output latency).
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset, int_req, SNGL, SP, inta_n;
  logic [2:0] highest_priority_idx, slave_id, cas_in;
  logic [4:0] vector_base;
  logic [7:0] cascade_mask;
  logic       INT, ack1, ack2, spurious, cas_oe, data_oe;
  logic [2:0] latched_idx, cas_out;
  logic [7:0] data_out;

  int tests = 0;
  int fails = 0;
  int ack1_cnt, ack2_cnt, overlap_cnt;

  always #5 clk = ~clk;

  inta_sequencer #(.SYNC_INTA(1'b0)) dut (
    .clk(clk), .reset(reset), .int_req(int_req), .highest_priority_idx(highest_priority_idx),
    .vector_base(vector_base), .SNGL(SNGL), .SP(SP), .cascade_mask(cascade_mask),
    .slave_id(slave_id), .inta_n(inta_n), .cas_in(cas_in), .INT(INT), .ack1(ack1),
    .ack2(ack2), .latched_idx(latched_idx), .spurious(spurious), .cas_out(cas_out),
    .cas_oe(cas_oe), .data_out(data_out), .data_oe(data_oe)
  );

  // Advance n cycles, sampling 1 ns after each rising edge and tallying strobes.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (ack1) ack1_cnt++;
      if (ack2) ack2_cnt++;
      if (ack1 && ack2) overlap_cnt++;
    end
  endtask

  task automatic clr_cnt();
    ack1_cnt = 0;
    ack2_cnt = 0;
    overlap_cnt = 0;
  endtask

  task automatic do_fall();
    inta_n = 1'b0;
    step(3);
  endtask

  task automatic do_rise();
    inta_n = 1'b1;
    step(3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    tests++;
    if ({INT, ack1, ack2, spurious, cas_oe, data_oe, latched_idx, cas_out, data_out} !== 20'd0) begin
      fails++;
      $display("FAIL reset_state: got INT=%b ack1=%b ack2=%b spur=%b cas_oe=%b data_oe=%b idx=%0d cas=%0d data=%h want all 0",
               INT, ack1, ack2, spurious, cas_oe, data_oe, latched_idx, cas_out, data_out);
    end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_single();
    clr_cnt();
    SNGL = 1'b1; SP = 1'b0; vector_base = 5'h08; highest_priority_idx = 3'd3; int_req = 1'b1;
    step(1);
    tests++; if (INT !== 1'b1) begin fails++; $display("FAIL single_int_rise: INT=%b want 1", INT); end
    step(2);
    inta_n = 1'b0;
    step(1);
    tests++; if (INT !== 1'b1) begin fails++; $display("FAIL single_int_hold: INT=%b want 1", INT); end
    step(1);
    tests++;
    if (INT !== 1'b0 || ack1 !== 1'b1 || latched_idx !== 3'd3) begin
      fails++; $display("FAIL single_pulse1: INT=%b ack1=%b idx=%0d want 0 1 3", INT, ack1, latched_idx);
    end
    int_req = 1'b0;
    step(1);
    do_rise();
    inta_n = 1'b0;
    step(1);
    tests++; if (data_oe !== 1'b0) begin fails++; $display("FAIL single_oe_early: data_oe=%b want 0", data_oe); end
    step(1);
    tests++;
    if (data_oe !== 1'b1 || data_out !== 8'h43) begin
      fails++; $display("FAIL single_vector: oe=%b data=%h want 1 43", data_oe, data_out);
    end
    step(2);
    inta_n = 1'b1;
    step(1);
    tests++;
    if (data_oe !== 1'b1 || ack2 !== 1'b0) begin
      fails++; $display("FAIL single_oe_hold: oe=%b ack2=%b want 1 0", data_oe, ack2);
    end
    step(1);
    tests++;
    if (ack2 !== 1'b1 || data_oe !== 1'b0) begin
      fails++; $display("FAIL single_ack2: ack2=%b oe=%b want 1 0", ack2, data_oe);
    end
    step(3);
    tests++;
    if (ack1_cnt != 1 || ack2_cnt != 1 || overlap_cnt != 0) begin
      fails++; $display("FAIL single_counts: ack1=%0d ack2=%0d overlap=%0d want 1 1 0",
                        ack1_cnt, ack2_cnt, overlap_cnt);
    end
  endtask

  task automatic test_spurious();
    clr_cnt();
    int_req = 1'b1; highest_priority_idx = 3'd4;
    step(2);
    int_req = 1'b0;
    do_fall();
    tests++;
    if (latched_idx !== 3'd7 || spurious !== 1'b1 || INT !== 1'b0) begin
      fails++; $display("FAIL spur_latch: idx=%0d spur=%b INT=%b want 7 1 0", latched_idx, spurious, INT);
    end
    do_rise();
    do_fall();
    tests++;
    if (data_oe !== 1'b1 || data_out !== 8'h47) begin
      fails++; $display("FAIL spur_vector: oe=%b data=%h want 1 47", data_oe, data_out);
    end
    do_rise();
    tests++;
    if (ack1_cnt != 0 || ack2_cnt != 0 || spurious !== 1'b0) begin
      fails++; $display("FAIL spur_acks: ack1=%0d ack2=%0d spur=%b want 0 0 0", ack1_cnt, ack2_cnt, spurious);
    end
  endtask

  task automatic test_master();
    clr_cnt();
    SNGL = 1'b0; SP = 1'b1; cascade_mask = 8'h04; highest_priority_idx = 3'd2; int_req = 1'b1;
    step(3);
    do_fall();
    tests++;
    if (cas_oe !== 1'b1 || cas_out !== 3'd2) begin
      fails++; $display("FAIL master_cas: oe=%b cas=%0d want 1 2", cas_oe, cas_out);
    end
    int_req = 1'b0;
    do_rise();
    do_fall();
    tests++;
    if (data_oe !== 1'b0 || cas_oe !== 1'b1) begin
      fails++; $display("FAIL master_pulse2: data_oe=%b cas_oe=%b want 0 1", data_oe, cas_oe);
    end
    do_rise();
    tests++;
    if (cas_oe !== 1'b0 || cas_out !== 3'd2 || ack1_cnt != 1 || ack2_cnt != 1) begin
      fails++; $display("FAIL master_end: cas_oe=%b cas=%0d ack1=%0d ack2=%0d want 0 2 1 1",
                        cas_oe, cas_out, ack1_cnt, ack2_cnt);
    end
  endtask

  task automatic test_slave(input logic [2:0] cin, input bit addressed);
    clr_cnt();
    SNGL = 1'b0; SP = 1'b0; slave_id = 3'd2; cas_in = cin; highest_priority_idx = 3'd5;
    int_req = 1'b1;
    step(1);
    tests++; if (INT !== 1'b1) begin fails++; $display("FAIL slave_int_%0d: INT=%b want 1", cin, INT); end
    step(2);
    do_fall();
    int_req = 1'b0;
    do_rise();
    do_fall();
    tests++;
    if (data_oe !== addressed || (addressed && data_out !== 8'h45)) begin
      fails++; $display("FAIL slave_data_%0d: oe=%b data=%h want oe %0d data 45", cin, data_oe, data_out,
                        addressed);
    end
    do_rise();
    tests++;
    if (ack1_cnt != int'(addressed) || ack2_cnt != int'(addressed) || overlap_cnt != 0) begin
      fails++; $display("FAIL slave_acks_%0d: ack1=%0d ack2=%0d overlap=%0d want %0d %0d 0",
                        cin, ack1_cnt, ack2_cnt, overlap_cnt, addressed, addressed);
    end
  endtask

  task automatic test_reset_gap();
    clr_cnt();
    SNGL = 1'b1; highest_priority_idx = 3'd3; int_req = 1'b1;
    step(3);
    do_fall();
    int_req = 1'b0;
    do_rise();
    reset = 1'b1;
    step(1);
    tests++;
    if ({INT, ack1, ack2, spurious, cas_oe, data_oe, latched_idx, cas_out, data_out} !== 20'd0) begin
      fails++; $display("FAIL reset_gap: INT=%b idx=%0d data=%h oe=%b want all 0", INT, latched_idx,
                        data_out, data_oe);
    end
    reset = 1'b0;
    step(2);
    clr_cnt();
    int_req = 1'b1;
    step(3);
    do_fall();
    int_req = 1'b0;
    do_rise();
    do_fall();
    tests++;
    if (data_oe !== 1'b1 || data_out !== 8'h43) begin
      fails++; $display("FAIL reset_recover_vec: oe=%b data=%h want 1 43", data_oe, data_out);
    end
    do_rise();
    tests++;
    if (ack1_cnt != 1 || ack2_cnt != 1) begin
      fails++; $display("FAIL reset_recover_acks: ack1=%0d ack2=%0d want 1 1", ack1_cnt, ack2_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clr_cnt();
    SNGL = 1'b1; highest_priority_idx = 3'd1; int_req = 1'b1;
    step(3);
    do_fall();
    do_rise();
    do_fall();
    inta_n = 1'b1;
    step(2);
    tests++; if (ack2 !== 1'b1) begin fails++; $display("FAIL b2b_ack2: ack2=%b want 1", ack2); end
    step(1);
    tests++; if (INT !== 1'b0) begin fails++; $display("FAIL b2b_holdoff: INT=%b want 0", INT); end
    step(1);
    tests++; if (INT !== 1'b1) begin fails++; $display("FAIL b2b_rerise: INT=%b want 1", INT); end
  endtask

  initial begin
    reset = 1'b1; int_req = 1'b0; SNGL = 1'b1; SP = 1'b0; inta_n = 1'b1;
    highest_priority_idx = 3'd0; slave_id = 3'd0; cas_in = 3'd0;
    vector_base = 5'h08; cascade_mask = 8'h00;
    clr_cnt();
    test_reset();
    test_single();
    test_spurious();
    test_master();
    test_slave(3'd2, 1'b1);
    test_slave(3'd5, 1'b0);
    test_reset_gap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
